// File: rtl/aibnd_dll_code_mon.sv
// DLL PVT reference code monitor: synchronizes the Gray code and lock, decodes and qualifies
// the code by stability, then requests a DLL reinit when the code drifts from the lock-time baseline.
module aibnd_dll_code_mon #(
    parameter int GRY_W      = 10,
    parameter int SYNC_STG   = 2,
    parameter int STABLE_CNT = 8,
    parameter int DRIFT_TH   = 16,
    parameter int REINIT_W   = 4
) (
    input  logic             clk_core,
    input  logic             nrst,
    input  logic             mon_en,
    input  logic             dll_lock,
    input  logic [GRY_W-1:0] pvt_ref_gry,
    output logic [GRY_W-1:0] code_bin,
    output logic             code_vld,
    output logic [GRY_W-1:0] base_code,
    output logic             drift_err,
    output logic             reinit,
    output logic [1:0]       mon_state
);

    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int RW = $clog2(REINIT_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TRACK  = 2'd2,
        ST_REINIT = 2'd3
    } state_t;

    logic [SYNC_STG-1:0] lock_sync_reg;
    logic [GRY_W-1:0]    gry_sync_reg [SYNC_STG];
    logic                lock_s;
    logic [GRY_W-1:0]    gry_s;
    logic [GRY_W-1:0]    dec_bin;

    logic [GRY_W-1:0]    code_bin_reg;
    logic [SW-1:0]       stab_cnt_reg;
    logic                code_vld_int;

    state_t              state_reg, state_next;
    logic [RW-1:0]       rcnt_reg, rcnt_next;
    logic                arm_reg, arm_next;
    logic [GRY_W-1:0]    base_reg, base_next;
    logic                drift_reg, drift_next;
    logic                reinit_reg;

    logic [GRY_W:0]      diff;
    logic [GRY_W:0]      diff_mag;
    logic                drift_hit;

    // Per-bit synchronizers; Gray coding keeps the multi-bit sample coherent.
    always_ff @(posedge clk_core or negedge nrst) begin
        if (!nrst) begin
            lock_sync_reg <= '0;
            for (int i = 0; i < SYNC_STG; i++) gry_sync_reg[i] <= '0;
        end else begin
            lock_sync_reg <= {lock_sync_reg[SYNC_STG-2:0], dll_lock};
            gry_sync_reg[0] <= pvt_ref_gry;
            for (int i = 1; i < SYNC_STG; i++) gry_sync_reg[i] <= gry_sync_reg[i-1];
        end
    end

    assign lock_s = lock_sync_reg[SYNC_STG-1];
    assign gry_s  = gry_sync_reg[SYNC_STG-1];

    generate
        for (genvar gi = 0; gi < GRY_W; gi++) begin : g_dec
            assign dec_bin[gi] = ^gry_s[GRY_W-1:gi];
        end
    endgenerate

    always_ff @(posedge clk_core or negedge nrst) begin
        if (!nrst) begin
            code_bin_reg <= '0;
            stab_cnt_reg <= '0;
        end else begin
            code_bin_reg <= dec_bin;
            if (dec_bin != code_bin_reg)
                stab_cnt_reg <= '0;
            else if (stab_cnt_reg != SW'(STABLE_CNT))
                stab_cnt_reg <= stab_cnt_reg + SW'(1);
        end
    end

    assign code_vld_int = (stab_cnt_reg == SW'(STABLE_CNT));

    // Widened by one bit so the difference never wraps before taking magnitude.
    assign diff      = {1'b0, code_bin_reg} - {1'b0, base_reg};
    assign diff_mag  = diff[GRY_W] ? (~diff + (GRY_W+1)'(1)) : diff;
    assign drift_hit = (diff_mag > (GRY_W+1)'(DRIFT_TH));

    always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        arm_next   = arm_reg;
        base_next  = base_reg;
        drift_next = drift_reg;

        if (!lock_s) arm_next = 1'b1;

        if (!mon_en) begin
            state_next = ST_IDLE;
            drift_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (lock_s && arm_reg) state_next = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        state_next = ST_IDLE;
                    end else if (code_vld_int) begin
                        base_next  = code_bin_reg;
                        state_next = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    // Lock loss outranks a coincident drift hit.
                    if (!lock_s) begin
                        state_next = ST_IDLE;
                    end else if (code_vld_int && drift_hit) begin
                        state_next = ST_REINIT;
                        drift_next = 1'b1;
                        rcnt_next  = '0;
                    end
                end
                ST_REINIT: begin
                    if (rcnt_reg == RW'(REINIT_W - 1)) begin
                        state_next = ST_IDLE;
                        arm_next   = 1'b0;
                    end else begin
                        rcnt_next = rcnt_reg + RW'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_core or negedge nrst) begin
        if (!nrst) begin
            state_reg  <= ST_IDLE;
            rcnt_reg   <= '0;
            arm_reg    <= 1'b1;
            base_reg   <= '0;
            drift_reg  <= 1'b0;
            reinit_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rcnt_reg   <= rcnt_next;
            arm_reg    <= arm_next;
            base_reg   <= base_next;
            drift_reg  <= drift_next;
            reinit_reg <= (state_next == ST_REINIT);
        end
    end

    assign code_bin  = code_bin_reg;
    assign code_vld  = code_vld_int;
    assign base_code = base_reg;
    assign drift_err = drift_reg;
    assign reinit    = reinit_reg;
    assign mon_state = state_reg;

endmodule

// File: tb/tb_aibnd_dll_code_mon.sv
// Directed bench for aibnd_dll_code_mon: Gray decode table plus hand-timed FSM sequences.
module tb_aibnd_dll_code_mon;

    logic       clk_core = 1'b0;
    logic       nrst;
    logic       mon_en;
    logic       dll_lock;
    logic [9:0] pvt_ref_gry;
    logic [9:0] code_bin;
    logic       code_vld;
    logic [9:0] base_code;
    logic       drift_err;
    logic       reinit;
    logic [1:0] mon_state;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [9:0] gry;
        logic [9:0] bin;
    } vec_t;

    vec_t tbl [7];

    aibnd_dll_code_mon dut (
        .clk_core    (clk_core),
        .nrst        (nrst),
        .mon_en      (mon_en),
        .dll_lock    (dll_lock),
        .pvt_ref_gry (pvt_ref_gry),
        .code_bin    (code_bin),
        .code_vld    (code_vld),
        .base_code   (base_code),
        .drift_err   (drift_err),
        .reinit      (reinit),
        .mon_state   (mon_state)
    );

    always #5 clk_core = ~clk_core;

    task automatic step(input int n);
        repeat (n) @(negedge clk_core);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic wait_state(input string name, input logic [1:0] target, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step(1);
            if (mon_state == target) break;
        end
        chk(name, 32'(mon_state), 32'(target));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        logic seen;

        tbl[0] = '{gry: 10'b0000110000, bin: 10'd32};
        tbl[1] = '{gry: 10'd768,        bin: 10'd512};
        tbl[2] = '{gry: 10'd7,          bin: 10'd5};
        tbl[3] = '{gry: 10'd511,        bin: 10'd341};
        tbl[4] = '{gry: 10'd512,        bin: 10'd1023};
        tbl[5] = '{gry: 10'd0,          bin: 10'd0};
        tbl[6] = '{gry: 10'd442,        bin: 10'd300};

        // Reset with random inputs
        nrst        = 1'b0;
        mon_en      = 1'($urandom);
        dll_lock    = 1'($urandom);
        pvt_ref_gry = 10'($urandom);
        step(6);
        chk("rst code_bin",  32'(code_bin),  0);
        chk("rst code_vld",  32'(code_vld),  0);
        chk("rst base_code", 32'(base_code), 0);
        chk("rst drift_err", 32'(drift_err), 0);
        chk("rst reinit",    32'(reinit),    0);
        chk("rst mon_state", 32'(mon_state), 0);
        mon_en      = 1'b0;
        dll_lock    = 1'b0;
        pvt_ref_gry = '0;
        step(1);
        nrst = 1'b1;
        step(3);
        chk("post-rst mon_state", 32'(mon_state), 0);
        chk("post-rst reinit",    32'(reinit),    0);
        chk("post-rst code_vld",  32'(code_vld),  0);

        // Decode table: latency 3, code_vld 8 cycles after code_bin update
        for (int v = 0; v < 7; v++) begin
            pvt_ref_gry = tbl[v].gry;
            step(2);
            chk($sformatf("vec%0d code_bin before latency", v), 32'(code_bin == tbl[v].bin), 0);
            step(1);
            chk($sformatf("vec%0d code_bin", v), 32'(code_bin), 32'(tbl[v].bin));
            chk($sformatf("vec%0d code_vld dropped", v), 32'(code_vld), 0);
            step(7);
            chk($sformatf("vec%0d code_vld at 7", v), 32'(code_vld), 0);
            step(1);
            chk($sformatf("vec%0d code_vld at 8", v), 32'(code_vld), 1);
        end

        // Lock with code 300 stable
        mon_en   = 1'b1;
        dll_lock = 1'b1;
        step(3);
        chk("settle state", 32'(mon_state), 1);
        step(1);
        chk("track state",  32'(mon_state), 2);
        chk("base 300",     32'(base_code), 300);
        chk("track reinit", 32'(reinit),    0);

        // +16: at threshold, no trip
        pvt_ref_gry = 10'd418;
        step(13);
        chk("316 code_bin",  32'(code_bin),  316);
        chk("316 code_vld",  32'(code_vld),  1);
        chk("316 state",     32'(mon_state), 2);
        chk("316 drift_err", 32'(drift_err), 0);

        // +17: trips once code_vld rises
        pvt_ref_gry = 10'd419;
        step(11);
        chk("317 pre-trip state", 32'(mon_state), 2);
        step(1);
        chk("317 reinit state", 32'(mon_state), 3);
        chk("317 drift_err",    32'(drift_err), 1);
        cnt = reinit ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (reinit) cnt++;
        end
        chk("reinit width",       32'(cnt),       4);
        chk("after reinit state", 32'(mon_state), 0);
        chk("drift_err sticky",   32'(drift_err), 1);
        chk("base held in idle",  32'(base_code), 300);
        step(20);
        chk("no rearm w/o lock toggle", 32'(mon_state), 0);

        // Lock toggle re-arms
        dll_lock = 1'b0;
        step(4);
        dll_lock = 1'b1;
        wait_state("relock track", 2'd2, 20);
        chk("base 317", 32'(base_code), 317);

        mon_en = 1'b0;
        step(2);
        chk("mon_en=0 drift_err", 32'(drift_err), 0);
        chk("mon_en=0 state",     32'(mon_state), 0);
        mon_en = 1'b1;
        wait_state("reenable track", 2'd2, 20);

        // Plain lock loss in TRACK
        dll_lock = 1'b0;
        step(2);
        chk("lock loss still track", 32'(mon_state), 2);
        step(1);
        chk("lock loss idle", 32'(mon_state), 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen = seen | reinit;
        end
        chk("lock loss no reinit",    32'(seen),      0);
        chk("lock loss drift_err",    32'(drift_err), 0);

        // Drift and lock loss arriving together: lock loss wins
        dll_lock = 1'b1;
        wait_state("relock2 track", 2'd2, 20);
        chk("base 317 again", 32'(base_code), 317);
        pvt_ref_gry = 10'd442;
        step(9);
        dll_lock = 1'b0;
        step(2);
        chk("simul code_vld", 32'(code_vld),  1);
        chk("simul state",    32'(mon_state), 2);
        step(1);
        chk("simul idle",      32'(mon_state), 0);
        chk("simul drift_err", 32'(drift_err), 0);
        chk("simul reinit",    32'(reinit),    0);

        // Downward boundary from base 300, then async reset mid-REINIT
        dll_lock = 1'b1;
        wait_state("relock3 track", 2'd2, 20);
        chk("base 300 again", 32'(base_code), 300);
        pvt_ref_gry = 10'd402;
        step(13);
        chk("284 code_bin", 32'(code_bin),  284);
        chk("284 state",    32'(mon_state), 2);
        pvt_ref_gry = 10'd406;
        step(11);
        chk("283 pre-trip state", 32'(mon_state), 2);
        step(1);
        chk("283 reinit state", 32'(mon_state), 3);
        step(1);
        chk("2nd reinit cycle", 32'(reinit), 1);
        nrst = 1'b0;
        #1;
        chk("async rst reinit",    32'(reinit),    0);
        chk("async rst state",     32'(mon_state), 0);
        chk("async rst base_code", 32'(base_code), 0);
        step(1);
        nrst = 1'b1;
        step(2);
        chk("after async rst state", 32'(mon_state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
